icache_refill: RTL

- Miss-refill engine for the instruction cache; it is the writer side of the per-way tag/valid and data-bank storage.
- Accepts one line-miss request at a time and issues a burst read on the memory-side read channel.
- Streams returned 32-bit beats one bank per cycle into the victim way, then commits the tag/valid entry.
- Pulses completion to the fetch pipeline.

---
 rtl/icache_refill.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/icache_refill.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | icache_refill : I-cache line-miss refill engine (burst read -> bank/tag). |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module icache_refill #(
  parameter int BANK      = 16,
  parameter int SET_WIDTH = 6,
  parameter int TAG       = 20,
  parameter int WAY       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [31:0]              miss_addr,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [31:0]              ar_addr,
  output logic [7:0]               ar_len,
  input  logic                     r_valid,
  output logic                     r_ready,
  input  logic [31:0]              r_data,
  input  logic                     r_last,
  input  logic                     r_err,
  output logic [WAY-1:0]           way_sel,
  output logic [BANK-1:0]          bank_we,
  output logic [SET_WIDTH-1:0]     bank_windex,
  output logic [31:0]              bank_wdata,
  output logic                     tagv_we,
  output logic [SET_WIDTH-1:0]     tagv_windex,
  output logic [TAG:0]             tagv_wdata,
  output logic                     refill_done,
  output logic                     refill_err,
  output logic [$clog2(WAY)-1:0]   refill_way
);

  localparam int c_BW  = $clog2(BANK);
  localparam int c_WW  = $clog2(WAY);
  localparam int c_OFF = 2 + c_BW;
  localparam int c_LW  = 32 - c_OFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_INVAL  = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_LW-1:0]     r_line;
  logic [c_BW-1:0]     r_cnt;
  logic [c_WW-1:0]     r_vcnt;
  logic [c_WW-1:0]     r_victim;
  logic                r_err_flag;

  logic [SET_WIDTH-1:0] w_index;
  logic [TAG-1:0]       w_tag;
  logic [WAY-1:0]       w_way_onehot;
  logic                 w_beat;
  logic                 w_at_max;
  logic                 w_beat_err;
  logic                 w_unused;

  assign w_unused     = &{1'b0, miss_addr[c_OFF-1:0]};
  assign w_index      = r_line[SET_WIDTH-1:0];
  assign w_tag        = r_line[SET_WIDTH +: TAG];
  assign w_way_onehot = WAY'(1) << r_victim;
  assign w_beat       = (r_state == S_DATA) && r_valid;
  assign w_at_max     = (r_cnt == c_BW'(BANK - 1));
  // A burst is well formed only if r_last coincides exactly with the final bank.
  assign w_beat_err   = r_err | (r_last ^ w_at_max);

  assign ar_addr     = {r_line, {c_OFF{1'b0}}};
  assign ar_len      = 8'(BANK - 1);
  assign bank_windex = w_index;
  assign tagv_windex = w_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_cnt      <= '0;
      r_vcnt     <= '0;
      r_victim   <= '0;
      r_err_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (miss_valid) begin
            r_line     <= miss_addr[31:c_OFF];
            r_victim   <= r_vcnt;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_beat_err) r_err_flag <= 1'b1;
          end
        end
        S_COMMIT: begin
          if (!r_err_flag) r_vcnt <= r_vcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    miss_ready  = 1'b0;
    ar_valid    = 1'b0;
    r_ready     = 1'b0;
    way_sel     = '0;
    bank_we     = '0;
    bank_wdata  = '0;
    tagv_we     = 1'b0;
    tagv_wdata  = '0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    refill_way  = '0;
    case (r_state)
      S_IDLE: begin
        // Held low while reset is applied so every output reads zero.
        miss_ready = !rst;
        if (miss_valid) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        ar_valid = 1'b1;
        if (ar_ready) w_state_nxt = S_INVAL;
      end
      S_INVAL: begin
        way_sel     = w_way_onehot;
        tagv_we     = 1'b1;
        tagv_wdata  = {1'b0, w_tag};
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        way_sel = w_way_onehot;
        r_ready = 1'b1;
        if (r_valid) begin
          bank_we    = BANK'(1) << r_cnt;
          bank_wdata = r_data;
          if (w_at_max || r_last) w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        way_sel = w_way_onehot;
        if (!r_err_flag) begin
          tagv_we    = 1'b1;
          tagv_wdata = {1'b1, w_tag};
        end
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        way_sel     = w_way_onehot;
        refill_done = 1'b1;
        refill_err  = r_err_flag;
        refill_way  = r_victim;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
